mem_stage_multi_outstanding: RTL
================================

Name: mem_stage_multi_outstanding

Overview:
Parametrised successor of the single-request MEM pipeline stage. It accepts memory and non-memory ops from EX and issues loads and stores on an SRAM-like request/response bus. Up to DEPTH requests may be outstanding, tracked in an in-order queue. Results retire to WB in program order, with load data aligned and extended. A flush discards all in-flight entries and silently absorbs any responses still owed.

Parameters:
DEPTH, 4, max entries in tracking queue (power of 2, >=2)
ADDR_W, 32, bus address width
DATA_W, 32, bus data width (fixed 32 for byte-lane logic)
PL_W, 70, width of opaque payload passed EX->WB (pc, rf_waddr, gr_we, ...)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
flush  in  1  discard all entries this cycle
in_valid  in  1  EX offers an op
in_ready  out  1  stage accepts the op
in_ld  in  1  op is a load
in_st  in  1  op is a store
in_size  in  2  00 byte, 01 half, 10 word
in_sign  in  1  sign-extend load
in_addr  in  ADDR_W  effective address (alignment checked upstream)
in_wdata  in  DATA_W  store source (rkd)
in_alu  in  DATA_W  result for non-memory ops
in_payload  in  PL_W  passthrough bundle
req  out  1  bus request
req_wr  out  1  1 = write
req_size  out  2  = entry size
req_wstrb  out  4  byte lanes
req_addr  out  ADDR_W  address
req_wdata  out  DATA_W  lane-replicated store data
addr_ok  in  1  request accepted (req & addr_ok = handshake)
data_ok  in  1  response, in request order
rdata  in  DATA_W  read data
out_valid  out  1  head entry complete
out_ready  in  1  WB accepts
out_data  out  DATA_W  aligned load data or in_alu
out_payload  out  PL_W  payload of head entry
fwd_valid  out  1  head entry complete and result available (bypass)
fwd_data  out  DATA_W  = out_data

Behaviour:
- Queue: DEPTH entries, head/issue/tail pointers (log2 DEPTH bits, wrap modulo DEPTH) plus count (log2 DEPTH + 1 bits). Each entry holds the op fields, payload, an issued flag and a done flag.
- Enqueue: on in_valid & in_ready. in_ready = (count < DEPTH) & ~flush.
- Non-memory op: enqueued with done=1 and issued=1; never appears on the bus.
- Issue: req = 1 when the entry at the issue pointer is a valid memory op with issued=0, and ~flush. Only one request per cycle, strictly in order. On req & addr_ok, set issued and advance the issue pointer.
- req may deassert before addr_ok only on flush.
- Write strobes:
  - byte: 0001 << addr[1:0]
  - half: addr[1] ? 1100 : 0011
  - word: 1111
  - loads: 0000
- Store data: byte replicated x4, half replicated x2.
- Response: data_ok completes the oldest issued, not-done entry (loads and stores both receive data_ok). Load results are captured aligned:
  - byte: rdata >> 8*addr[1:0], zero- or sign-extend by in_sign
  - half: rdata >> 16*addr[1], extend likewise
  - word: unchanged
- Retire: out_valid = count>0 & head.done & ~flush. On out_valid & out_ready, pop the head. Enqueue, issue, response and retire may all occur in one cycle; count updates by net +1/0/-1.
- Latency: minimum 2 cycles in-to-out for a memory op (enqueue cycle; same-cycle addr_ok and next-cycle data_ok); 1 cycle for a non-memory op. Full throughput is 1 op/cycle with no back-pressure.
- Flush:
  - all entries are invalidated and all pointers and count cleared next cycle;
  - discard counter (log2 DEPTH + 1 bits) += number of entries with issued=1 and done=0, plus 1 if req & addr_ok in the flush cycle;
  - while the discard counter > 0, each data_ok decrements it and is dropped (no entry completes);
  - new enqueues are allowed the cycle after flush; their responses arrive after the discarded ones.
- Simultaneous flush & data_ok: that response counts against pre-flush entries. If it completes an issued entry, that entry is not added to the discard count.
- Reset (async, rst low): count, pointers and discard counter = 0; all valid/done/issued flags = 0. req, out_valid and fwd_valid = 0; in_ready = 0 while rst low. All data outputs = 0.
- A data_ok that arrives with no issued entry pending and discard counter = 0 is a protocol violation; assert it in simulation.

Test Plan:
- Single ld_b, addr 0x1003, rdata 0x80FF_FF00, sign=1, addr_ok same cycle, data_ok next -> out_data 0xFFFF_FF80, out_valid 2 cycles after enqueue.
- Back-to-back 4 loads, addr_ok immediate, data_ok withheld 5 cycles, then 4 consecutive data_ok (rdata 1,2,3,4) -> in_ready low at count=4; out_data 1,2,3,4 in order.
- st_h addr 0x2002, wdata 0x1234_ABCD -> req_wr=1, wstrb 1100, req_wdata 0xABCD_ABCD; retires after data_ok with out_valid.
- 3 loads issued, flush, then a new ld_w issued; 4 data_ok (rdata A,B,C,D) -> first three dropped, new load out_data = D.
- Mixed ALU op (0x55) behind a pending load, out_ready low for 3 cycles -> ALU op waits behind load; in-order retire, no loss or duplication.
- rst asserted low mid-traffic with 2 outstanding -> all outputs 0 asynchronously; after release, count=0 and in_ready=1.

Source files
------------

// File: rtl/mem_stage_multi_outstanding.sv
// MEM stage with an in-order tracking queue: up to DEPTH loads/stores outstanding on an
// SRAM-like bus, results retired to WB in program order, flush absorbs responses still owed.
module mem_stage_multi_outstanding #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned PL_W   = 70
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_ld,
  input  logic              in_st,
  input  logic [1:0]        in_size,
  input  logic              in_sign,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic [DATA_W-1:0] in_alu,
  input  logic [PL_W-1:0]   in_payload,
  output logic              req,
  output logic              req_wr,
  output logic [1:0]        req_size,
  output logic [3:0]        req_wstrb,
  output logic [ADDR_W-1:0] req_addr,
  output logic [DATA_W-1:0] req_wdata,
  input  logic              addr_ok,
  input  logic              data_ok,
  input  logic [DATA_W-1:0] rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [PL_W-1:0]   out_payload,
  output logic              fwd_valid,
  output logic [DATA_W-1:0] fwd_data
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SUM_W = CNT_W + 1;

  // Control flags (reset) and per-entry op fields (no reset, qualified by r_valid)
  logic [DEPTH-1:0]  r_valid, r_issued, r_done;
  logic [DEPTH-1:0]  r_ld, r_st, r_sign;
  logic [1:0]        r_size  [DEPTH];
  logic [ADDR_W-1:0] r_addr  [DEPTH];
  logic [DATA_W-1:0] r_wdata [DEPTH];
  logic [DATA_W-1:0] r_data  [DEPTH];
  logic [PL_W-1:0]   r_pl    [DEPTH];

  logic [PTR_W-1:0]  r_head, r_iss, r_tail;
  logic [CNT_W-1:0]  r_count, r_disc;

  logic              w_full, w_enq, w_in_mem, w_q_req, w_byp, w_hs, w_q_hs;
  logic              w_skip, w_enq_adv, w_pop;
  logic              w_rsp_found, w_rsp_drop, w_rsp_cmp;
  logic [PTR_W-1:0]  w_rsp_idx, w_scan;
  logic [CNT_W-1:0]  w_pend_cnt;
  logic [SUM_W-1:0]  w_disc_sum;
  logic [DATA_W-1:0] w_ld_res;
  logic              w_src_st;
  logic [1:0]        w_src_size;
  logic [ADDR_W-1:0] w_src_addr;
  logic [DATA_W-1:0] w_src_wdata;

  function automatic logic [31:0] f_align(input logic [31:0] d, input logic [1:0] a,
                                          input logic [1:0] sz, input logic sg);
    logic [31:0] sh;
    sh = 32'h0;
    f_align = d;
    case (sz)
      2'b00: begin
        sh = d >> {a, 3'b000};
        f_align = {{24{sg & sh[7]}}, sh[7:0]};
      end
      2'b01: begin
        sh = d >> {a[1], 4'b0000};
        f_align = {{16{sg & sh[15]}}, sh[15:0]};
      end
      default: f_align = d;
    endcase
  endfunction

  function automatic logic [3:0] f_strb(input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      2'b00:   f_strb = 4'b0001 << a;
      2'b01:   f_strb = a[1] ? 4'b1100 : 4'b0011;
      default: f_strb = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] f_repl(input logic [1:0] sz, input logic [31:0] w);
    case (sz)
      2'b00:   f_repl = {4{w[7:0]}};
      2'b01:   f_repl = {2{w[15:0]}};
      default: f_repl = w;
    endcase
  endfunction

  assign w_full   = (r_count == CNT_W'(DEPTH));
  assign in_ready = rst & ~w_full & ~flush;
  assign w_enq    = in_valid & in_ready;
  assign w_in_mem = in_ld | in_st;

  // Issue: oldest unissued queue entry, or the incoming op when everything ahead is issued
  assign w_q_req   = r_valid[r_iss] & ~r_issued[r_iss];
  assign w_byp     = w_enq & w_in_mem & (r_iss == r_tail);
  assign req       = (w_q_req | w_byp) & ~flush;
  assign w_hs      = req & addr_ok;
  assign w_q_hs    = w_hs & w_q_req;
  assign w_skip    = r_valid[r_iss] & r_issued[r_iss];
  assign w_enq_adv = w_enq & (r_iss == r_tail) & (~w_in_mem | addr_ok);

  assign w_src_st    = w_q_req ? r_st[r_iss]    : in_st;
  assign w_src_size  = w_q_req ? r_size[r_iss]  : in_size;
  assign w_src_addr  = w_q_req ? r_addr[r_iss]  : in_addr;
  assign w_src_wdata = w_q_req ? r_wdata[r_iss] : in_wdata;

  assign req_wr    = req & w_src_st;
  assign req_size  = req ? w_src_size : 2'b00;
  assign req_addr  = req ? w_src_addr : '0;
  assign req_wstrb = req_wr ? f_strb(w_src_size, w_src_addr[1:0]) : 4'b0000;
  assign req_wdata = req_wr ? f_repl(w_src_size, w_src_wdata) : '0;

  assign out_valid   = (r_count != '0) & r_valid[r_head] & r_done[r_head] & ~flush;
  assign w_pop       = out_valid & out_ready;
  assign out_data    = out_valid ? r_data[r_head] : '0;
  assign out_payload = out_valid ? r_pl[r_head] : '0;
  assign fwd_valid   = out_valid;
  assign fwd_data    = out_data;

  // Oldest issued-but-not-done entry receives the next response
  always_comb begin
    w_rsp_found = 1'b0;
    w_rsp_idx   = '0;
    w_scan      = r_head;
    w_pend_cnt  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      w_scan = r_head + PTR_W'(i);
      if (!w_rsp_found && r_valid[w_scan] && r_issued[w_scan] && !r_done[w_scan]) begin
        w_rsp_found = 1'b1;
        w_rsp_idx   = w_scan;
      end
      w_pend_cnt = w_pend_cnt + CNT_W'(r_valid[i] & r_issued[i] & ~r_done[i]);
    end
  end

  assign w_rsp_drop = data_ok & (r_disc != '0);
  assign w_rsp_cmp  = data_ok & (r_disc == '0) & w_rsp_found;
  assign w_ld_res   = f_align(rdata, r_addr[w_rsp_idx][1:0], r_size[w_rsp_idx], r_sign[w_rsp_idx]);
  assign w_disc_sum = SUM_W'(r_disc) + SUM_W'(w_pend_cnt) + SUM_W'(w_hs)
                    - SUM_W'(w_rsp_drop | w_rsp_cmp);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid  <= '0;
      r_issued <= '0;
      r_done   <= '0;
      r_head   <= '0;
      r_iss    <= '0;
      r_tail   <= '0;
      r_count  <= '0;
      r_disc   <= '0;
    end else if (flush) begin
      r_valid  <= '0;
      r_issued <= '0;
      r_done   <= '0;
      r_head   <= '0;
      r_iss    <= '0;
      r_tail   <= '0;
      r_count  <= '0;
      r_disc   <= CNT_W'(w_disc_sum);
    end else begin
      if (w_enq) begin
        r_valid[r_tail]  <= 1'b1;
        r_issued[r_tail] <= ~w_in_mem | w_hs;
        r_done[r_tail]   <= ~w_in_mem;
      end
      if (w_q_hs)    r_issued[r_iss]  <= 1'b1;
      if (w_rsp_cmp) r_done[w_rsp_idx] <= 1'b1;
      if (w_pop) begin
        r_valid[r_head]  <= 1'b0;
        r_issued[r_head] <= 1'b0;
        r_done[r_head]   <= 1'b0;
      end
      r_head  <= r_head + PTR_W'(w_pop);
      r_tail  <= r_tail + PTR_W'(w_enq);
      r_iss   <= r_iss + PTR_W'(w_q_hs | w_skip | w_enq_adv);
      r_count <= r_count + CNT_W'(w_enq) - CNT_W'(w_pop);
      if (w_rsp_drop) r_disc <= r_disc - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_ld[r_tail]    <= in_ld;
      r_st[r_tail]    <= in_st;
      r_sign[r_tail]  <= in_sign;
      r_size[r_tail]  <= in_size;
      r_addr[r_tail]  <= in_addr;
      r_wdata[r_tail] <= in_wdata;
      r_data[r_tail]  <= in_alu;
      r_pl[r_tail]    <= in_payload;
    end
    if (w_rsp_cmp && r_ld[w_rsp_idx]) r_data[w_rsp_idx] <= w_ld_res;
  end

  a_no_orphan_rsp: assert property (@(posedge clk) disable iff (!rst)
    !(data_ok && (r_disc == '0) && !w_rsp_found));

endmodule
